// File: rtl/seg7_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_reader_if
//  Purpose  : Bundles the segment inputs, the error-clear request and the
//             decoded readback outputs of the seg7_reader block.
//  Signals  : seg_ten/seg_one [6:0] - segments a..g on bit6..bit0
//             clr_err               - synchronous clear of err_count
//             bcd_ten/bcd_one [3:0] - last accepted digits
//             valid, invalid        - status of the last accepted pattern
//             update, step_err      - one-cycle event pulses
//             err_count [7:0]       - saturating sequence-error count
//  Modports : master - drives the segments and clr_err, observes results
//             slave  - the reader itself
//  Revision : 1.0 - initial release
// ============================================================================
interface seg7_reader_if;
    logic [6:0] seg_ten;
    logic [6:0] seg_one;
    logic       clr_err;
    logic [3:0] bcd_ten;
    logic [3:0] bcd_one;
    logic       valid;
    logic       invalid;
    logic       update;
    logic       step_err;
    logic [7:0] err_count;

    modport master (
        output seg_ten, seg_one, clr_err,
        input  bcd_ten, bcd_one, valid, invalid, update, step_err, err_count
    );

    modport slave (
        input  seg_ten, seg_one, clr_err,
        output bcd_ten, bcd_one, valid, invalid, update, step_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_reader
//  Purpose  : Reads back a two-digit 7-segment display (tens and ones),
//             debounces the captured pattern, decodes it to BCD, flags
//             undecodable patterns and checks that successive accepted
//             values advance by +1 modulo MOD.
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous, active-low
//             bus   - seg7_reader_if.slave (segments in, readback out)
//  Params   : STABLE_CYCLES - identical samples needed to accept (2..15)
//             counter modulus parameter MOD (2..100)
//             ACTIVE_LOW    - 1 = segment inputs are active-low
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int MOD           = 60,
    parameter int ACTIVE_LOW    = 0
) (
    input  wire logic      clk,
    input  wire logic      reset,
    seg7_reader_if.slave   bus
);

    localparam logic [3:0] c_stable  = 4'(STABLE_CYCLES);
    localparam logic [6:0] c_mod     = 7'(MOD);
    localparam logic [6:0] c_mod_max = 7'(MOD - 1);
    localparam logic [7:0] c_err_max = 8'd255;

    // ------------------------------------------------------------------
    // Segment-code to digit decode. Returns {decodable, digit}.
    // ------------------------------------------------------------------
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h7E:   res = {1'b1, 4'd0};
            7'h30:   res = {1'b1, 4'd1};
            7'h6D:   res = {1'b1, 4'd2};
            7'h79:   res = {1'b1, 4'd3};
            7'h33:   res = {1'b1, 4'd4};
            7'h5B:   res = {1'b1, 4'd5};
            7'h5F:   res = {1'b1, 4'd6};
            7'h70:   res = {1'b1, 4'd7};
            7'h7F:   res = {1'b1, 4'd8};
            7'h7B:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Polarity normalisation: everything downstream is active-high.
    // ------------------------------------------------------------------
    logic [13:0] w_raw;
    logic [13:0] w_norm;

    assign w_raw = {bus.seg_ten, bus.seg_one};

    generate
        if (ACTIVE_LOW != 0) begin : g_norm_inv
            assign w_norm = ~w_raw;
        end else begin : g_norm_pass
            assign w_norm = w_raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [13:0] r_s;          // pattern seen at the previous edge
    logic [3:0]  r_cnt;        // length of the current identical run
    logic [6:0]  r_p;          // previous accepted value
    logic        r_p_valid;    // r_p holds something to step-check against
    logic [3:0]  r_bcd_ten;
    logic [3:0]  r_bcd_one;
    logic        r_valid;
    logic        r_invalid;
    logic        r_update;
    logic        r_step_err;
    logic [7:0]  r_err_count;

    // ------------------------------------------------------------------
    // Debounce and decode
    // ------------------------------------------------------------------
    logic       w_same;
    logic       w_accept;
    logic [4:0] w_dec_ten;
    logic [4:0] w_dec_one;
    logic       w_decodable;
    logic [6:0] w_value;
    logic [6:0] w_p_next;
    logic       w_range_err;
    logic       w_seq_err;
    logic       w_step;

    assign w_same = (w_norm == r_s);

    // The run reaches STABLE_CYCLES exactly on this edge; once the counter
    // sits at STABLE_CYCLES it holds, so a run is accepted only once.
    assign w_accept = w_same && (r_cnt == (c_stable - 4'd1));

    assign w_dec_ten   = f_decode(w_norm[13:7]);
    assign w_dec_one   = f_decode(w_norm[6:0]);
    assign w_decodable = w_dec_ten[4] & w_dec_one[4];

    // Tens digit scaled by ten plus ones digit; at most 99, fits 7 bits.
    assign w_value = ({3'b000, w_dec_ten[3:0]} * 7'd10) + {3'b000, w_dec_one[3:0]};

    assign w_p_next    = (r_p == c_mod_max) ? 7'd0 : (r_p + 7'd1);
    assign w_range_err = (w_value >= c_mod);

    // Equal to the previous value is a harmless re-accept after a glitch.
    assign w_seq_err = r_p_valid && (w_value != r_p) && (w_value != w_p_next);

    // Out-of-range values are errors even with no previous value to compare.
    assign w_step = w_accept && w_decodable && (w_range_err || w_seq_err);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s         <= 14'd0;
            r_cnt       <= 4'd0;
            r_p         <= 7'd0;
            r_p_valid   <= 1'b0;
            r_bcd_ten   <= 4'd0;
            r_bcd_one   <= 4'd0;
            r_valid     <= 1'b0;
            r_invalid   <= 1'b0;
            r_update    <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_s        <= w_norm;
            r_update   <= 1'b0;
            r_step_err <= w_step;

            if (!w_same) begin
                r_cnt <= 4'd1;
            end else if (r_cnt < c_stable) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_accept) begin
                if (w_decodable) begin
                    r_bcd_ten <= w_dec_ten[3:0];
                    r_bcd_one <= w_dec_one[3:0];
                    r_valid   <= 1'b1;
                    r_invalid <= 1'b0;
                    r_update  <= 1'b1;
                    r_p       <= w_value;
                    r_p_valid <= 1'b1;
                end else begin
                    // Digits hold; forget the previous value so the next
                    // good pattern resynchronises without a step check.
                    r_valid   <= 1'b0;
                    r_invalid <= 1'b1;
                    r_p_valid <= 1'b0;
                end
            end

            // Clear takes priority over a coincident increment.
            if (bus.clr_err) begin
                r_err_count <= 8'd0;
            end else if (w_step && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.bcd_ten   = r_bcd_ten;
    assign bus.bcd_one   = r_bcd_one;
    assign bus.valid     = r_valid;
    assign bus.invalid   = r_invalid;
    assign bus.update    = r_update;
    assign bus.step_err  = r_step_err;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_reader
//  Purpose  : Self-checking bench for seg7_reader. One instance uses
//             active-high segments, a second uses active-low segments.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_reader;

    logic clk;
    logic reset;

    seg7_reader_if ifa ();
    seg7_reader_if ifb ();

    seg7_reader #(.STABLE_CYCLES(4), .MOD(60), .ACTIVE_LOW(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    seg7_reader #(.STABLE_CYCLES(4), .MOD(60), .ACTIVE_LOW(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_upd  = 0;
    int n_step = 0;

    typedef struct {
        logic [6:0] st;
        logic [6:0] so;
        int         hold;
        int         e_ten;
        int         e_one;
        int         e_valid;
        int         e_inv;
        int         e_upd;
        int         e_step;
        int         e_err;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] r;
        case (d)
            0: r = 7'h7E;  1: r = 7'h30;  2: r = 7'h6D;  3: r = 7'h79;
            4: r = 7'h33;  5: r = 7'h5B;  6: r = 7'h5F;  7: r = 7'h70;
            8: r = 7'h7F;  9: r = 7'h7B;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge, sampled 1 time unit later; counts dut_a event pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ifa.update)   n_upd++;
        if (ifa.step_err) n_step++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_a(input int ten, input int one);
        ifa.seg_ten = seg_of(ten);
        ifa.seg_one = seg_of(one);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ifa.seg_ten = 7'h00;
        ifa.seg_one = 7'h00;
        ifa.clr_err = 1'b0;
        hold(2);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        ifa.seg_ten = 7'h00; ifa.seg_one = 7'h00; ifa.clr_err = 1'b0;
        ifb.seg_ten = 7'h00; ifb.seg_one = 7'h00; ifb.clr_err = 1'b0;

        //           st           so           hold ten one v  i  upd stp err
        vecs[0]  = '{seg_of(1),  seg_of(2),  6,   1,  2,  1, 0, 1,  0,  0};
        vecs[1]  = '{seg_of(1),  seg_of(3),  3,   1,  2,  1, 0, 0,  0,  0};
        vecs[2]  = '{seg_of(1),  seg_of(2),  2,   1,  2,  1, 0, 0,  0,  0};
        vecs[3]  = '{seg_of(1),  seg_of(3),  4,   1,  3,  1, 0, 1,  0,  0};
        vecs[4]  = '{seg_of(8),  seg_of(8),  2,   1,  3,  1, 0, 0,  0,  0};
        vecs[5]  = '{seg_of(1),  seg_of(3),  5,   1,  3,  1, 0, 1,  0,  0};
        vecs[6]  = '{seg_of(1),  seg_of(5),  4,   1,  5,  1, 0, 1,  1,  1};
        vecs[7]  = '{seg_of(6),  seg_of(2),  4,   6,  2,  1, 0, 1,  1,  2};
        vecs[8]  = '{seg_of(2),  seg_of(5),  4,   2,  5,  1, 0, 1,  1,  3};
        vecs[9]  = '{seg_of(2),  seg_of(6),  4,   2,  6,  1, 0, 1,  0,  3};
        vecs[10] = '{seg_of(2),  7'h00,      4,   2,  6,  0, 1, 0,  0,  3};
        vecs[11] = '{seg_of(3),  seg_of(7),  4,   3,  7,  1, 0, 1,  0,  3};
        vecs[12] = '{seg_of(3),  seg_of(8),  4,   3,  8,  1, 0, 1,  0,  3};
        vecs[13] = '{7'h7E,      7'h01,      4,   3,  8,  0, 1, 0,  0,  3};
        vecs[14] = '{seg_of(7),  seg_of(5),  4,   7,  5,  1, 0, 1,  1,  4};
        vecs[15] = '{seg_of(0),  seg_of(0),  4,   0,  0,  1, 0, 1,  1,  5};
        vecs[16] = '{seg_of(5),  seg_of(9),  4,   5,  9,  1, 0, 1,  1,  6};
        vecs[17] = '{seg_of(0),  seg_of(0),  4,   0,  0,  1, 0, 1,  0,  6};
        vecs[18] = '{seg_of(0),  seg_of(1),  4,   0,  1,  1, 0, 1,  0,  6};

        // ---------------- reset state and first acceptance ----------------
        do_reset();
        chk("reset bcd_ten",   int'(ifa.bcd_ten),   0);
        chk("reset bcd_one",   int'(ifa.bcd_one),   0);
        chk("reset valid",     int'(ifa.valid),     0);
        chk("reset invalid",   int'(ifa.invalid),   0);
        chk("reset update",    int'(ifa.update),    0);
        chk("reset step_err",  int'(ifa.step_err),  0);
        chk("reset err_count", int'(ifa.err_count), 0);

        drive_a(0, 0);
        hold(3);
        chk("first edge3 update", int'(ifa.update), 0);
        chk("first edge3 valid",  int'(ifa.valid),  0);
        hold(1);
        chk("first edge4 update",   int'(ifa.update),   1);
        chk("first edge4 valid",    int'(ifa.valid),    1);
        chk("first edge4 bcd_ten",  int'(ifa.bcd_ten),  0);
        chk("first edge4 bcd_one",  int'(ifa.bcd_one),  0);
        chk("first edge4 step_err", int'(ifa.step_err), 0);
        hold(1);
        chk("first edge5 update", int'(ifa.update), 0);

        // ---------------- full sweep 00..59 then 00 ----------------
        do_reset();
        n_upd = 0; n_step = 0;
        for (int v = 0; v <= 60; v++) begin
            drive_a((v % 60) / 10, (v % 60) % 10);
            hold(10);
        end
        chk("sweep updates",  n_upd,  61);
        chk("sweep step_err", n_step, 0);
        chk("sweep bcd_ten",  int'(ifa.bcd_ten),   0);
        chk("sweep bcd_one",  int'(ifa.bcd_one),   0);
        chk("sweep err",      int'(ifa.err_count), 0);

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int k = 0; k < 19; k++) begin
            ifa.seg_ten = vecs[k].st;
            ifa.seg_one = vecs[k].so;
            n_upd = 0; n_step = 0;
            hold(vecs[k].hold);
            chk($sformatf("vec%0d bcd_ten", k),  int'(ifa.bcd_ten),   vecs[k].e_ten);
            chk($sformatf("vec%0d bcd_one", k),  int'(ifa.bcd_one),   vecs[k].e_one);
            chk($sformatf("vec%0d valid", k),    int'(ifa.valid),     vecs[k].e_valid);
            chk($sformatf("vec%0d invalid", k),  int'(ifa.invalid),   vecs[k].e_inv);
            chk($sformatf("vec%0d updates", k),  n_upd,               vecs[k].e_upd);
            chk($sformatf("vec%0d step_errs", k), n_step,             vecs[k].e_step);
            chk($sformatf("vec%0d err_count", k), int'(ifa.err_count), vecs[k].e_err);
        end

        // ---------------- clear, saturation, clear-vs-increment ----------------
        ifa.clr_err = 1'b1;
        hold(1);
        ifa.clr_err = 1'b0;
        chk("clr err_count", int'(ifa.err_count), 0);

        // Current value is 01; every +2 step is a skip.
        n_step = 0;
        for (int i = 1; i <= 300; i++) begin
            drive_a(((1 + 2 * i) % 60) / 10, ((1 + 2 * i) % 60) % 10);
            hold(4);
        end
        chk("sat step_errs", n_step, 300);
        chk("sat err_count", int'(ifa.err_count), 255);

        drive_a(((1 + 2 * 301) % 60) / 10, ((1 + 2 * 301) % 60) % 10);
        n_step = 0;
        hold(3);
        chk("clrhit pre step_errs", n_step, 0);
        ifa.clr_err = 1'b1;
        hold(1);
        chk("clrhit step_err",  int'(ifa.step_err),  1);
        chk("clrhit err_count", int'(ifa.err_count), 0);
        ifa.clr_err = 1'b0;
        hold(1);
        chk("clrhit after err_count", int'(ifa.err_count), 0);
        chk("clrhit after step_err",  int'(ifa.step_err),  0);

        // ---------------- active-low instance ----------------
        ifb.seg_ten = 7'h01;
        ifb.seg_one = 7'h01;
        hold(3);
        chk("actlow edge3 update", int'(ifb.update), 0);
        hold(1);
        chk("actlow update",  int'(ifb.update),  1);
        chk("actlow valid",   int'(ifb.valid),   1);
        chk("actlow bcd_ten", int'(ifb.bcd_ten), 0);
        chk("actlow bcd_one", int'(ifb.bcd_one), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
